fbf_stream_loader: RTL and testbench

Streaming front/back end for the 4x4 single-precision matrix adder (`fbf_adder`). It accepts 32 IEEE-754 words one at a time over a strobe/ack handshake, packs them into the 512-bit A and B operand buses, and drives the adder's `A_stb`/`B_stb`. It then waits for `result_ready`, acknowledges and captures the 512-bit result, and streams the 16 result words back out over a second strobe/ack port.

---
 rtl/fbf_pkg.sv | 20 ++
 rtl/fbf_stream_loader_mat_word_reg.sv | 31 +++
 rtl/fbf_stream_loader.sv | 135 +++++++++++++
 tb/tb_fbf_stream_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fbf_pkg.sv
// Shared types and sizes for the fbf stream loader.
// Matrix geometry, counter width and FSM state encoding.
package fbf_pkg;
  localparam int DIM      = 4;
  localparam int WIDTH    = 32;
  localparam int NELEM    = DIM * DIM;
  localparam int MAT_BITS = NELEM * WIDTH;
  localparam int IDX_BITS = $clog2(NELEM);

  localparam logic [IDX_BITS-1:0] LAST_IDX =
    IDX_BITS'(NELEM - 1);

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    WAIT,
    ACK,
    DRAIN
  } state_t;
endpackage

// File: rtl/fbf_stream_loader_mat_word_reg.sv
// Matrix-wide register with word write, word read
// and whole-matrix parallel load.
module mat_word_reg
  import fbf_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                ld_en,
  input  logic [MAT_BITS-1:0] ld_data,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [WIDTH-1:0]    rd_data,
  output logic [MAT_BITS-1:0] q
);

  // parallel load wins over a single-word write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (ld_en) begin
      q <= ld_data;
    end else if (wr_en) begin
      q[wr_idx*WIDTH +: WIDTH] <= wr_data;
    end
  end

  assign rd_data = q[rd_idx*WIDTH +: WIDTH];

endmodule

// File: rtl/fbf_stream_loader.sv
// Streams 32 operand words into the matrix adder and
// streams the 16 result words back out.
module fbf_stream_loader
  import fbf_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                in_stb,
  output logic                in_ack,
  output logic [MAT_BITS-1:0] A,
  output logic [MAT_BITS-1:0] B,
  output logic                A_stb,
  output logic                B_stb,
  input  logic [MAT_BITS-1:0] result,
  input  logic                result_ready,
  output logic                result_ack,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_stb,
  input  logic                out_ack
);

  state_t              state, state_nxt;
  logic [IDX_BITS-1:0] k, k_nxt;
  logic                a_wr, b_wr, res_ld;
  logic [WIDTH-1:0]    unused_a_rd, unused_b_rd;
  logic [MAT_BITS-1:0] unused_res_q;

  // state register and shared element counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LOAD_A;
      k     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  // next state, counter and buffer write controls
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    a_wr      = 1'b0;
    b_wr      = 1'b0;
    res_ld    = 1'b0;
    unique case (state)
      LOAD_A: if (in_stb) begin
        a_wr = 1'b1;
        if (k == LAST_IDX) begin
          k_nxt     = '0;
          state_nxt = LOAD_B;
        end else begin
          k_nxt = k + 1'b1;
        end
      end
      LOAD_B: if (in_stb) begin
        b_wr = 1'b1;
        if (k == LAST_IDX) begin
          k_nxt     = '0;
          state_nxt = WAIT;
        end else begin
          k_nxt = k + 1'b1;
        end
      end
      WAIT: if (result_ready) begin
        res_ld    = 1'b1;
        state_nxt = ACK;
      end
      ACK: begin
        k_nxt     = '0;
        state_nxt = DRAIN;
      end
      DRAIN: if (out_ack) begin
        if (k == LAST_IDX) begin
          k_nxt     = '0;
          state_nxt = LOAD_A;
        end else begin
          k_nxt = k + 1'b1;
        end
      end
      default: begin
        k_nxt     = '0;
        state_nxt = LOAD_A;
      end
    endcase
  end

  assign in_ack     = (state == LOAD_A) ||
                      (state == LOAD_B);
  assign A_stb      = (state == WAIT);
  assign B_stb      = (state == WAIT);
  assign result_ack = (state == ACK);
  assign out_stb    = (state == DRAIN);

  mat_word_reg u_a (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (a_wr),
    .wr_idx  (k),
    .wr_data (in_data),
    .ld_en   (1'b0),
    .ld_data ({MAT_BITS{1'b0}}),
    .rd_idx  (k),
    .rd_data (unused_a_rd),
    .q       (A)
  );

  mat_word_reg u_b (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (b_wr),
    .wr_idx  (k),
    .wr_data (in_data),
    .ld_en   (1'b0),
    .ld_data ({MAT_BITS{1'b0}}),
    .rd_idx  (k),
    .rd_data (unused_b_rd),
    .q       (B)
  );

  mat_word_reg u_res (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (1'b0),
    .wr_idx  ({IDX_BITS{1'b0}}),
    .wr_data ({WIDTH{1'b0}}),
    .ld_en   (res_ld),
    .ld_data (result),
    .rd_idx  (k),
    .rd_data (out_data),
    .q       (unused_res_q)
  );

endmodule

// File: tb/tb_fbf_stream_loader.sv
// Self-checking bench for fbf_stream_loader.
// The bench plays both the stream peers and the adder.
module tb_fbf_stream_loader;
  import fbf_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic [WIDTH-1:0]    in_data;
  logic                in_stb;
  logic                in_ack;
  logic [MAT_BITS-1:0] A, B;
  logic                A_stb, B_stb;
  logic [MAT_BITS-1:0] result;
  logic                result_ready;
  logic                result_ack;
  logic [WIDTH-1:0]    out_data;
  logic                out_stb;
  logic                out_ack;

  int checks = 0;
  int failures = 0;

  logic [31:0]         words [32];
  logic [31:0]         sums  [16];
  logic [MAT_BITS-1:0] exp_a, exp_b, res_bus;

  fbf_stream_loader dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_stb       (in_stb),
    .in_ack       (in_ack),
    .A            (A),
    .B            (B),
    .A_stb        (A_stb),
    .B_stb        (B_stb),
    .result       (result),
    .result_ready (result_ready),
    .result_ack   (result_ack),
    .out_data     (out_data),
    .out_stb      (out_stb),
    .out_ack      (out_ack)
  );

  always #5 clk = ~clk;

  // Build one operand set and the adder's answer.
  task automatic fill(input logic [31:0] a0,
                      input logic [31:0] b0,
                      input logic [31:0] r0);
    for (int i = 0; i < 32; i++) words[i] = $urandom;
    for (int i = 0; i < 16; i++) sums[i] = $urandom;
    words[0]  = a0;
    words[16] = b0;
    sums[0]   = r0;
    for (int i = 0; i < 16; i++) begin
      exp_a[32*i +: 32]   = words[i];
      exp_b[32*i +: 32]   = words[16+i];
      res_bus[32*i +: 32] = sums[i];
    end
  endtask

  // Feed words[0..stop-1]; optional stray result_ready.
  task automatic do_load(input int stall_pct,
                         input int rr_at,
                         input int stop);
    int idx = 0;
    int guard = 0;
    bit pulsed = 0;
    while (idx < stop) begin
      @(negedge clk);
      result_ready = 1'b0;
      checks++;
      if (in_ack !== 1'b1 || A_stb !== 1'b0 ||
          B_stb !== 1'b0 || result_ack !== 1'b0 ||
          out_stb !== 1'b0) begin
        failures++;
        $display("FAIL load_status idx=%0d got ack=%b as=%b bs=%b ra=%b os=%b exp 1 0 0 0 0",
                 idx, in_ack, A_stb, B_stb, result_ack, out_stb);
      end
      if (idx == rr_at && !pulsed) begin
        pulsed = 1;
        result = ~res_bus;
        result_ready = 1'b1;
        in_stb = 1'b0;
        in_data = $urandom;
      end else begin
        in_stb = ($urandom_range(99) >= stall_pct);
        in_data = in_stb ? words[idx] : $urandom;
        if (in_stb) idx++;
      end
      guard++;
      if (guard > 2000) begin
        failures++;
        $display("FAIL load_timeout got idx=%0d exp %0d", idx, stop);
        break;
      end
    end
    @(negedge clk);
    in_stb = 1'b0;
    result_ready = 1'b0;
  endtask

  // After the last B word the operands must be presented.
  task automatic check_operands();
    checks++;
    if (A_stb !== 1'b1 || B_stb !== 1'b1 || in_ack !== 1'b0) begin
      failures++;
      $display("FAIL operand_strobes got as=%b bs=%b ack=%b exp 1 1 0",
               A_stb, B_stb, in_ack);
    end
    checks++;
    if (A !== exp_a) begin
      failures++;
      $display("FAIL bus_a got=%h exp=%h", A, exp_a);
    end
    checks++;
    if (B !== exp_b) begin
      failures++;
      $display("FAIL bus_b got=%h exp=%h", B, exp_b);
    end
  endtask

  // Adder: wait lat cycles, then present the sum.
  task automatic do_adder(input int lat);
    for (int c = 0; c < lat; c++) begin
      checks++;
      if (A_stb !== 1'b1 || B_stb !== 1'b1 ||
          result_ack !== 1'b0 || A !== exp_a || B !== exp_b) begin
        failures++;
        $display("FAIL wait_hold cyc=%0d got as=%b bs=%b ra=%b exp 1 1 0",
                 c, A_stb, B_stb, result_ack);
      end
      @(negedge clk);
    end
    result = res_bus;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    result = ~res_bus;
    checks++;
    if (result_ack !== 1'b1 || A_stb !== 1'b0 ||
        B_stb !== 1'b0 || out_stb !== 1'b0) begin
      failures++;
      $display("FAIL ack_cycle got ra=%b as=%b bs=%b os=%b exp 1 0 0 0",
               result_ack, A_stb, B_stb, out_stb);
    end
    @(negedge clk);
    checks++;
    if (result_ack !== 1'b0 || out_stb !== 1'b1) begin
      failures++;
      $display("FAIL ack_end got ra=%b os=%b exp 0 1",
               result_ack, out_stb);
    end
  endtask

  // Consume 16 result words with random stalls.
  task automatic do_drain(input int stall_pct);
    int idx = 0;
    int guard = 0;
    while (idx < 16) begin
      checks++;
      if (out_stb !== 1'b1 || in_ack !== 1'b0 ||
          out_data !== sums[idx]) begin
        failures++;
        $display("FAIL drain_word idx=%0d got os=%b ia=%b d=%h exp 1 0 %h",
                 idx, out_stb, in_ack, out_data, sums[idx]);
      end
      out_ack = ($urandom_range(99) >= stall_pct);
      if (out_ack) idx++;
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        failures++;
        $display("FAIL drain_timeout got idx=%0d exp 16", idx);
        break;
      end
    end
    out_ack = 1'b0;
    checks++;
    if (in_ack !== 1'b1 || out_stb !== 1'b0) begin
      failures++;
      $display("FAIL drain_done got ia=%b os=%b exp 1 0",
               in_ack, out_stb);
    end
  endtask

  task automatic run_pass(input int stall_pct, input int lat);
    do_load(stall_pct, -1, 32);
    check_operands();
    do_adder(lat);
    do_drain(stall_pct);
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (in_ack !== 1'b1 || A_stb !== 1'b0 || B_stb !== 1'b0 ||
        result_ack !== 1'b0 || out_stb !== 1'b0) begin
      failures++;
      $display("FAIL %s_ctrl got ia=%b as=%b bs=%b ra=%b os=%b exp 1 0 0 0 0",
               tag, in_ack, A_stb, B_stb, result_ack, out_stb);
    end
    checks++;
    if (A !== '0 || B !== '0) begin
      failures++;
      $display("FAIL %s_bus got A=%h B=%h exp 0", tag, A, B);
    end
    checks++;
    if (out_data !== '0) begin
      failures++;
      $display("FAIL %s_out got=%h exp=0", tag, out_data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
  endtask

  task automatic test_full_pass();
    fill(32'h3F99999A, 32'h415A147B, 32'h416D47AE);
    run_pass(0, 1);
  endtask

  task automatic test_backpressure();
    for (int r = 0; r < 2; r++) begin
      fill($urandom, $urandom, $urandom);
      run_pass(50, 2);
    end
  endtask

  task automatic test_stray();
    fill($urandom, $urandom, $urandom);
    out_ack = 1'b1;
    do_load(0, 21, 32);
    out_ack = 1'b0;
    check_operands();
    do_adder(2);
    do_drain(0);
  endtask

  task automatic test_handshake();
    fill($urandom, $urandom, $urandom);
    run_pass(0, 5);
  endtask

  task automatic test_reset_mid();
    fill($urandom, $urandom, $urandom);
    do_load(20, -1, 20);
    #2 reset = 1'b0;
    #1 check_reset_values("reset_mid");
    @(negedge clk);
    reset = 1'b1;
    fill($urandom, $urandom, $urandom);
    run_pass(30, 3);
  endtask

  task automatic test_back_to_back();
    fill(32'h3F99999A, 32'h415A147B, 32'h416D47AE);
    run_pass(0, 1);
    fill(32'h40BAE148, 32'h41A73333, 32'h41D5EB85);
    run_pass(0, 1);
  endtask

  initial begin
    reset = 1'b0;
    in_data = '0;
    in_stb = 1'b0;
    result = '0;
    result_ready = 1'b0;
    out_ack = 1'b0;
    test_reset();
    test_full_pass();
    test_backpressure();
    test_stray();
    test_handshake();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
